// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter controller for instruction fetch.
//
// Owns the PC register and an IDLE/RUN/HALTED state machine. Start, halt,
// stall and branch requests from decode are sampled on each rising edge and
// take effect on pc_o/state_o at that same edge.
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   reset_i     synchronous active-high reset, overrides every other input
//   start_i     load startadd_i into PC, clear count, enter RUN
//   startadd_i  start address (PC_W)
//   halt_i      stop sequencing, enter HALTED (RUN only)
//   stall_i     hold PC and count this cycle (RUN only)
//   branchf_i   forward branch: pc + target_i + 1
//   branchb_i   backward branch: pc - target_i + 1
//   target_i    branch offset (PC_W)
//   pc_o        current fetch address (registered)
//   fetch_o     fetch strobe, high in RUN when not stalled
//   done_o      high while HALTED
//   count_o     saturating count of PC advances since last start (CNT_W)
//   state_o     IDLE=00, RUN=01, HALTED=10
//
// Handshake: there is no back-pressure; every request input is a level
// sampled at the rising edge. A branch presented during a stall is dropped,
// so the producer must hold it until a cycle in which stall_i is low.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  startadd_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             branchf_i,
  input  logic             branchb_i,
  input  logic [PC_W-1:0]  target_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10,
    S_BAD    = 2'b11
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) begin
          pc_d    = startadd_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (start_i) begin
          pc_d  = startadd_i;
          cnt_d = '0;
        end else if (halt_i) begin
          state_d = S_HALTED;
        end else if (!stall_i) begin
          advance = 1'b1;
          // Forward branch wins when both branch requests are raised.
          if (branchf_i)      pc_d = pc_q + target_i + PC_ONE;
          else if (branchb_i) pc_d = pc_q - target_i + PC_ONE;
          else                pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean IDLE.
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    if (advance && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  assign pc_o    = pc_q;
  assign count_o = cnt_q;
  assign state_o = state_q;
  assign done_o  = (state_q == S_HALTED);
  assign fetch_o = (state_q == S_RUN) && !stall_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (CNT_W reduced to 4 so
// saturation is reachable). The driver applies one request vector per cycle
// at the falling edge, advances a behavioural model and queues the expected
// registered outputs and fetch strobe; two monitors pop and compare.
module tb_pc_sequencer;
  localparam int PC_W  = 8;
  localparam int CNT_W = 4;
  localparam int EW    = 2 + PC_W + CNT_W + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, halt, stall, branchf, branchb;
  logic [PC_W-1:0]  startadd, target;
  logic [PC_W-1:0]  pc;
  logic             fetch, done;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;

  pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .startadd_i(startadd),
    .halt_i(halt), .stall_i(stall), .branchf_i(branchf), .branchb_i(branchb),
    .target_i(target), .pc_o(pc), .fetch_o(fetch), .done_o(done),
    .count_o(count), .state_o(state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];   // {state, pc, count, done} after the next edge
  logic          fexp_q[$];  // fetch strobe for the vector just applied
  int vectors = 0;
  int miscompares = 0;

  // behavioural model: 0=IDLE 1=RUN 2=HALTED
  int m_state = 0, m_pc = 0, m_cnt = 0;
  bit m_known = 0;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  task automatic cyc(input bit r, input bit s, input int sa, input bit h,
                     input bit st, input bit bf, input bit bb, input int tg);
    logic [EW-1:0] e;
    @(negedge clk);
    reset = r; start = s; startadd = PC_W'(sa); halt = h; stall = st;
    branchf = bf; branchb = bb; target = PC_W'(tg);
    if (m_known) fexp_q.push_back(m_state == 1 && !st);
    if (r) begin
      m_state = 0; m_pc = 0; m_cnt = 0; m_known = 1;
    end else if (m_known) begin
      if (s) begin
        m_state = 1; m_pc = sa % PC_MOD; m_cnt = 0;
      end else if (m_state == 1) begin
        if (h) m_state = 2;
        else if (!st) begin
          if (bf)      m_pc = (m_pc + tg + 1) % PC_MOD;
          else if (bb) m_pc = (m_pc - tg + 1 + PC_MOD) % PC_MOD;
          else         m_pc = (m_pc + 1) % PC_MOD;
          if (m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
        end
      end
    end
    if (m_known) begin
      e = {2'(m_state), PC_W'(m_pc), CNT_W'(m_cnt), (m_state == 2)};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: registered outputs, just after each rising edge
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, pc, count, done};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL regs t=%0t: got state=%b pc=%h count=%0d done=%b, want state=%b pc=%h count=%0d done=%b",
                   $time, a[EW-1 -: 2], a[EW-3 -: PC_W], a[CNT_W:1], a[0],
                   e[EW-1 -: 2], e[EW-3 -: PC_W], e[CNT_W:1], e[0]);
        end
      end
    end
  end

  // monitor: combinational fetch strobe, after inputs settle
  initial begin
    logic f;
    forever begin
      @(negedge clk);
      #1;
      if (fexp_q.size() > 0) begin
        f = fexp_q.pop_front();
        vectors++;
        if (fetch !== f) begin
          miscompares++;
          $display("FAIL fetch t=%0t: got %b, want %b", $time, fetch, f);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset = 1; start = 0; startadd = '0; halt = 0; stall = 0;
    branchf = 0; branchb = 0; target = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    cyc(0, 0, 0, 1, 1, 1, 1, 7);          // IDLE ignores all but start
    cyc(0, 1, 8'h00, 0, 0, 0, 0, 0);      // start at 0x00
    idle_cyc();                           // -> 0x01, count 1
    cyc(0, 1, 8'h00, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h29);      // -> 0x2A
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h05);      // -> 0x26
    idle_cyc();                           // -> 0x27, count 3
    cyc(0, 1, 8'h00, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'hFE);      // -> 0xFF
    idle_cyc();                           // -> 0x00 wrap
    cyc(0, 1, 8'hFE, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 8'hFF);      // -> 0x00 borrow wrap
    cyc(0, 0, 0, 0, 1, 1, 0, 8'h20);      // stalled branch held
    cyc(0, 0, 0, 0, 1, 1, 0, 8'h20);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h20);      // applied once
    cyc(0, 1, 8'h10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 8'h03);      // forward wins -> 0x14
    cyc(0, 0, 0, 1, 0, 0, 0, 0);          // halt
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
    cyc(0, 1, 8'h80, 0, 0, 0, 0, 0);      // restart from HALTED
    idle_cyc();
    cyc(1, 0, 0, 0, 1, 1, 0, 8'h11);      // reset mid-run, stall+branch high
    cyc(0, 1, 8'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 2; i++) idle_cyc();  // saturate
    cyc(0, 0, 0, 0, 1, 0, 0, 0);          // stall at saturation
    idle_cyc();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
          $urandom_range(0, 255), $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 25, $urandom_range(0, 255));
    end
    idle_cyc();
    // drain with a bounded wait
    for (int i = 0; i < 10 && (exp_q.size() > 0 || fexp_q.size() > 0); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0 || fexp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0",
               exp_q.size() + fexp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
